// File: rtl/pep_mmacc_body_corr_ser.sv
// Serializes key-switch mod-switch error beats (ERR_NB elements, masked) into single-element
// body RAM correction writes. Define MMACC_BODY_CORR_CHECK_EN for per-pid completion/overflow tracking.
module pep_mmacc_body_corr_ser #(
`ifdef MMACC_BODY_CORR_CHECK_EN
  parameter int TOTAL_PBS_NB   = 16,
  parameter int LWE_K          = 8,
  parameter int LWE_K_WW       = 4,
`endif
  parameter int ERR_NB         = 4,
  parameter int PID_W          = 4,
  parameter int KS_MAX_ERROR_W = 8
) (
  input  logic                             clk,
  input  logic                             s_rst_n,
  input  logic [ERR_NB*KS_MAX_ERROR_W-1:0] ks_corr_data,
  input  logic [ERR_NB-1:0]                ks_corr_mask,
  input  logic [PID_W-1:0]                 ks_corr_pid,
  input  logic                             ks_corr_vld,
  output logic                             ks_corr_rdy,
  output logic                             seq_boram_corr_wr_en,
  output logic [KS_MAX_ERROR_W-1:0]        seq_boram_corr_wr_data,
  output logic [PID_W-1:0]                 seq_boram_corr_wr_pid,
  output logic                             ser_busy,
  output logic                             corr_done,
  output logic [PID_W-1:0]                 corr_done_pid,
  output logic                             corr_ovf_err
);

  localparam int DATA_W = ERR_NB * KS_MAX_ERROR_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SER  = 1'b1;

  // 2-deep input buffer
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [ERR_NB-1:0] fifo_mask_q [2];
  logic [PID_W-1:0]  fifo_pid_q  [2];
  logic              fifo_wp_q, fifo_rp_q;
  logic [1:0]        fifo_cnt_q;
  logic              fifo_push, fifo_pop, fifo_out_vld;

  assign fifo_out_vld = (fifo_cnt_q != 2'd0);
  assign ks_corr_rdy  = s_rst_n & (fifo_cnt_q != 2'd2);
  assign fifo_push    = ks_corr_vld & ks_corr_rdy;

  // NOTE: buffer storage has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data_q[fifo_wp_q] <= ks_corr_data;
      fifo_mask_q[fifo_wp_q] <= ks_corr_mask;
      fifo_pid_q[fifo_wp_q]  <= ks_corr_pid;
    end
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      fifo_wp_q  <= 1'b0;
      fifo_rp_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (fifo_push) fifo_wp_q <= ~fifo_wp_q;
      if (fifo_pop)  fifo_rp_q <= ~fifo_rp_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end
  end

  logic [0:0]                state_q, state_d;
  logic [ERR_NB-1:0]         work_mask_q, cur_mask, low_bit, rem_mask;
  logic [DATA_W-1:0]         work_data_q, cur_data;
  logic [PID_W-1:0]          work_pid_q, cur_pid;
  logic                      cur_vld, emit;
  logic [KS_MAX_ERROR_W-1:0] sel_data;
  logic                      wr_en_q;
  logic [KS_MAX_ERROR_W-1:0] wr_data_q;
  logic [PID_W-1:0]          wr_pid_q;

  // In IDLE the fifo head is consumed directly, so its first element leaves without a bubble.
  // NOTE: every always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    cur_mask = fifo_mask_q[fifo_rp_q];
    cur_data = fifo_data_q[fifo_rp_q];
    cur_pid  = fifo_pid_q[fifo_rp_q];
    fifo_pop = 1'b0;
    if (state_q == ST_SER) begin
      cur_mask = work_mask_q;
      cur_data = work_data_q;
      cur_pid  = work_pid_q;
    end else begin
      fifo_pop = fifo_out_vld;
    end
    cur_vld  = (state_q == ST_SER) | fifo_out_vld;
    low_bit  = cur_mask & (~cur_mask + ERR_NB'(1));
    rem_mask = cur_mask & ~low_bit;
    sel_data = '0;
    for (int i = 0; i < ERR_NB; i++) begin
      if (low_bit[i]) sel_data = cur_data[i*KS_MAX_ERROR_W +: KS_MAX_ERROR_W];
    end
    emit    = cur_vld & (|cur_mask);
    state_d = (cur_vld && (|rem_mask)) ? ST_SER : ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state_q <= ST_IDLE;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= emit;
    end
  end

  always_ff @(posedge clk) begin
    work_mask_q <= rem_mask;
    if (fifo_pop) begin
      work_data_q <= cur_data;
      work_pid_q  <= cur_pid;
    end
    if (emit) begin
      wr_data_q <= sel_data;
      wr_pid_q  <= cur_pid;
    end
  end

  assign seq_boram_corr_wr_en   = wr_en_q;
  assign seq_boram_corr_wr_data = wr_data_q;
  assign seq_boram_corr_wr_pid  = wr_pid_q;
  assign ser_busy               = fifo_out_vld | (state_q == ST_SER) | wr_en_q;

`ifdef MMACC_BODY_CORR_CHECK_EN
  logic [LWE_K_WW-1:0] tbl_q [TOTAL_PBS_NB];
  logic [LWE_K_WW-1:0] wr_cnt, pop_cnt;
  logic                done_hit, ovf_hit, ovf_q;
  int                  pop_eff;

  // The write on the output this cycle is not yet in the table; a count landing on LWE_K wraps to 0.
  always_comb begin
    wr_cnt   = tbl_q[wr_pid_q];
    done_hit = wr_en_q && ((int'(wr_cnt) + 1) == LWE_K);
    pop_cnt  = tbl_q[cur_pid];
    pop_eff  = int'(pop_cnt) + ((wr_en_q && (wr_pid_q == cur_pid)) ? 1 : 0);
    if (pop_eff == LWE_K) pop_eff = 0;
    ovf_hit  = fifo_pop && ((pop_eff + $countones(cur_mask)) > LWE_K);
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      for (int i = 0; i < TOTAL_PBS_NB; i++) tbl_q[i] <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en_q) tbl_q[wr_pid_q] <= done_hit ? '0 : wr_cnt + 1'b1;
      if (ovf_hit) ovf_q <= 1'b1;
    end
  end

  assign corr_done     = done_hit;
  assign corr_done_pid = wr_pid_q;
  assign corr_ovf_err  = ovf_q;
`else
  assign corr_done     = 1'b0;
  assign corr_done_pid = '0;
  assign corr_ovf_err  = 1'b0;
`endif

endmodule

// File: tb/tb_pep_mmacc_body_corr_ser.sv
// Directed bench for pep_mmacc_body_corr_ser: single-beat vector table plus multi-beat sequences.
// Works in both builds; expectations for the check feature follow MMACC_BODY_CORR_CHECK_EN.
module tb_pep_mmacc_body_corr_ser;

`ifdef MMACC_BODY_CORR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        s_rst_n;
  logic [31:0] ks_corr_data;
  logic [3:0]  ks_corr_mask;
  logic [3:0]  ks_corr_pid;
  logic        ks_corr_vld;
  logic        ks_corr_rdy;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [3:0]  wr_pid;
  logic        ser_busy;
  logic        corr_done;
  logic [3:0]  corr_done_pid;
  logic        corr_ovf_err;

  pep_mmacc_body_corr_ser #(
    .ERR_NB(4), .PID_W(4), .KS_MAX_ERROR_W(8)
  ) dut (
    .clk(clk), .s_rst_n(s_rst_n),
    .ks_corr_data(ks_corr_data), .ks_corr_mask(ks_corr_mask),
    .ks_corr_pid(ks_corr_pid), .ks_corr_vld(ks_corr_vld), .ks_corr_rdy(ks_corr_rdy),
    .seq_boram_corr_wr_en(wr_en), .seq_boram_corr_wr_data(wr_data),
    .seq_boram_corr_wr_pid(wr_pid), .ser_busy(ser_busy),
    .corr_done(corr_done), .corr_done_pid(corr_done_pid), .corr_ovf_err(corr_ovf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] pid;
    logic [7:0] data;
    logic       done;
    logic [3:0] done_pid;
  } wr_t;
  wr_t wq[$];

  always begin
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) wq.push_back('{cyc, wr_pid, wr_data, corr_done, corr_done_pid});
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a beat and holds vld until accepted; acc is the cycle whose closing edge takes it.
  task automatic send(input logic [3:0] pid, input logic [3:0] mask, input logic [31:0] data,
                      output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    ks_corr_pid  = pid;
    ks_corr_mask = mask;
    ks_corr_data = data;
    ks_corr_vld  = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      if (ks_corr_rdy === 1'b1) begin
        acc = cyc;
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("accept", {31'd0, got}, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  pid;
    logic [3:0]  mask;
    logic [31:0] data;
    int          exp_n;
    logic [31:0] exp_wr;
  } vec_t;
  vec_t vecs[6];

  int acc, acc0, acc1, acc2;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // element k of exp_wr sits at [k*8 +: 8]
    vecs[0] = '{4'd3,  4'b1011, 32'hFF07_05FE, 3, 32'h00FF_05FE};
    vecs[1] = '{4'd9,  4'b1111, 32'h807F_0100, 4, 32'h807F_0100};
    vecs[2] = '{4'd15, 4'b1000, 32'h813C_3C3C, 1, 32'h0000_0081};
    vecs[3] = '{4'd12, 4'b0110, 32'h1122_3344, 2, 32'h0000_2233};
    vecs[4] = '{4'd6,  4'b0000, 32'hDEAD_BEEF, 0, 32'h0000_0000};
    vecs[5] = '{4'd10, 4'b0001, 32'h7777_77C8, 1, 32'h0000_00C8};

    s_rst_n      = 1'b0;
    ks_corr_vld  = 1'b0;
    ks_corr_data = '0;
    ks_corr_mask = '0;
    ks_corr_pid  = '0;
    tick(3);
    check("rst_rdy",   {31'd0, ks_corr_rdy},  32'd0);
    check("rst_wr_en", {31'd0, wr_en},        32'd0);
    check("rst_busy",  {31'd0, ser_busy},     32'd0);
    check("rst_done",  {31'd0, corr_done},    32'd0);
    check("rst_ovf",   {31'd0, corr_ovf_err}, 32'd0);
    s_rst_n = 1'b1;
    tick(2);
    check("rdy_after_rst", {31'd0, ks_corr_rdy}, 32'd1);

    // single-beat vectors
    for (int v = 0; v < 6; v++) begin
      wq.delete();
      send(vecs[v].pid, vecs[v].mask, vecs[v].data, acc);
      ks_corr_vld = 1'b0;
      tick(8);
      check($sformatf("v%0d_nwr", v), wq.size(), vecs[v].exp_n);
      for (int k = 0; k < vecs[v].exp_n && k < wq.size(); k++) begin
        check($sformatf("v%0d_data%0d", v, k), {24'd0, wq[k].data}, {24'd0, vecs[v].exp_wr[k*8 +: 8]});
        check($sformatf("v%0d_pid%0d", v, k),  {28'd0, wq[k].pid},  {28'd0, vecs[v].pid});
        check($sformatf("v%0d_cyc%0d", v, k),  wq[k].cyc, acc + 2 + k);
      end
      check($sformatf("v%0d_idle_busy", v), {31'd0, ser_busy}, 32'd0);
    end

    // three back-to-back full beats pid 0,1,0; beat b element i = 0x10*b + i
    wq.delete();
    send(4'd0, 4'b1111, 32'h0302_0100, acc0);
    send(4'd1, 4'b1111, 32'h1312_1110, acc1);
    send(4'd0, 4'b1111, 32'h2322_2120, acc2);
    check("b2b_rdy_full", {31'd0, ks_corr_rdy}, 32'd0);
    ks_corr_vld = 1'b0;
    check("b2b_acc1", acc1, acc0 + 1);
    check("b2b_acc2", acc2, acc0 + 2);
    tick(16);
    check("b2b_nwr", wq.size(), 12);
    for (int k = 0; k < 12 && k < wq.size(); k++) begin
      check($sformatf("b2b_cyc%0d", k),  wq[k].cyc, acc0 + 2 + k);
      check($sformatf("b2b_pid%0d", k),  {28'd0, wq[k].pid}, (k / 4 == 1) ? 32'd1 : 32'd0);
      check($sformatf("b2b_data%0d", k), {24'd0, wq[k].data}, 16 * (k / 4) + (k % 4));
      check($sformatf("b2b_done%0d", k), {31'd0, wq[k].done}, (CHK && k == 11) ? 32'd1 : 32'd0);
    end
    if (wq.size() >= 12) check("b2b_done_pid", {28'd0, wq[11].done_pid}, 32'd0);
    check("b2b_ovf", {31'd0, corr_ovf_err}, 32'd0);

    // mask-0 beat between two single-element beats
    wq.delete();
    send(4'd7, 4'b0001, 32'h0000_005A, acc0);
    send(4'd7, 4'b0000, 32'hFFFF_FFFF, acc1);
    send(4'd7, 4'b0001, 32'h0000_00A5, acc2);
    ks_corr_vld = 1'b0;
    tick(8);
    check("z_acc2", acc2, acc0 + 2);
    check("z_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      check("z_cyc0",  wq[0].cyc, acc0 + 2);
      check("z_gap",   wq[1].cyc, wq[0].cyc + 2);
      check("z_data0", {24'd0, wq[0].data}, 32'h5A);
      check("z_data1", {24'd0, wq[1].data}, 32'hA5);
    end
    check("z_busy", {31'd0, ser_busy}, 32'd0);

    // reset one cycle after accepting a full beat
    send(4'd4, 4'b1111, 32'h0403_0201, acc);
    ks_corr_vld = 1'b0;
    wq.delete();
    s_rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", {31'd0, ks_corr_rdy}, 32'd0);
    tick(2);
    s_rst_n = 1'b1;
    tick(6);
    check("mid_rst_nwr", wq.size(), 0);
    check("mid_rst_busy", {31'd0, ser_busy}, 32'd0);
    send(4'd4, 4'b0101, 32'h4433_2211, acc);
    ks_corr_vld = 1'b0;
    tick(6);
    check("post_rst_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      check("post_rst_cyc0",  wq[0].cyc, acc + 2);
      check("post_rst_data0", {24'd0, wq[0].data}, 32'h11);
      check("post_rst_data1", {24'd0, wq[1].data}, 32'h33);
    end

    // pid 5: two full beats then a single element, all back-to-back; element k = 0xE0 + k
    wq.delete();
    send(4'd5, 4'b1111, 32'hE3E2_E1E0, acc0);
    send(4'd5, 4'b1111, 32'hE7E6_E5E4, acc1);
    send(4'd5, 4'b0001, 32'h0000_00E8, acc2);
    ks_corr_vld = 1'b0;
    tick(14);
    check("p5_nwr", wq.size(), 9);
    for (int k = 0; k < 9 && k < wq.size(); k++) begin
      check($sformatf("p5_cyc%0d", k),  wq[k].cyc, acc0 + 2 + k);
      check($sformatf("p5_data%0d", k), {24'd0, wq[k].data}, 32'hE0 + k);
      check($sformatf("p5_done%0d", k), {31'd0, wq[k].done}, (CHK && k == 7) ? 32'd1 : 32'd0);
    end
    if (wq.size() >= 8) check("p5_done_pid", {28'd0, wq[7].done_pid}, CHK ? 32'd5 : 32'd0);
    check("p5_no_ovf", {31'd0, corr_ovf_err}, 32'd0);

    // pid 2: 7 elements, then a 2-element beat overflows LWE_K=8
    wq.delete();
    send(4'd2, 4'b1111, 32'h2322_2120, acc0);
    send(4'd2, 4'b0111, 32'hFF26_2524, acc1);
    ks_corr_vld = 1'b0;
    tick(10);
    check("p2_nwr7", wq.size(), 7);
    check("p2_ovf_pre", {31'd0, corr_ovf_err}, 32'd0);
    wq.delete();
    send(4'd2, 4'b0011, 32'h0000_2827, acc);
    ks_corr_vld = 1'b0;
    tick(6);
    check("p2_nwr2", wq.size(), 2);
    if (wq.size() == 2) begin
      check("p2_data0", {24'd0, wq[0].data}, 32'h27);
      check("p2_data1", {24'd0, wq[1].data}, 32'h28);
      check("p2_done0", {31'd0, wq[0].done}, CHK ? 32'd1 : 32'd0);
    end
    check("p2_ovf", {31'd0, corr_ovf_err}, CHK ? 32'd1 : 32'd0);
    tick(5);
    check("p2_ovf_sticky", {31'd0, corr_ovf_err}, CHK ? 32'd1 : 32'd0);
    s_rst_n = 1'b0;
    tick(1);
    check("p2_ovf_rst", {31'd0, corr_ovf_err}, 32'd0);
    s_rst_n = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
